// File: rtl/core_pkg.sv
// Shared core constants and writeback types used by the register-file
// writeback arbiter and its scoreboard.
package core_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set when decode issues a writer, cleared when
// the regfile write retires. Register 0 is never busy.
module rf_scoreboard
  import core_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          idle
);
  logic [NREG-1:1] busy_reg;
  logic [NREG-1:0] busy;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      // Set has priority: a new producer issued in the same cycle as the old
      // one retires must keep the register marked busy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_en && (set_addr == AW'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (clr_en && (clr_addr == AW'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy     = {busy_reg, 1'b0};
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
  assign idle     = ~(|busy_reg) & ~clr_en;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between the ALU
// pipe (A) and the load/mul-div unit (B), with registered write outputs.
module rf_wb_arbiter
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            idle
);
  gnt_e            last_gnt_reg;
  gnt_e            last_gnt_next;
  wb_req_t         a_req;
  wb_req_t         b_req;
  wb_req_t         sel_req;
  logic            xfer;
  logic            wr_en_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic [XLEN-1:0] wr_data_reg;

  assign a_req = '{addr: a_addr, data: a_data};
  assign b_req = '{addr: b_addr, data: b_data};

  always_comb begin
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    last_gnt_next = last_gnt_reg;
    sel_req       = b_req;
    // On a tie the source that did not win last time goes first.
    a_ready = a_valid & (~b_valid | (last_gnt_reg == GNT_B));
    b_ready = b_valid & ~a_ready;
    if (a_ready) begin
      last_gnt_next = GNT_A;
      sel_req       = a_req;
    end else if (b_ready) begin
      last_gnt_next = GNT_B;
    end
  end

  assign xfer = a_ready | b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_reg <= GNT_B;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      last_gnt_reg <= last_gnt_next;
      // x0 writes are consumed here but never reach the regfile.
      wr_en_reg    <= xfer && (sel_req.addr != '0);
      if (xfer) begin
        wr_addr_reg <= sel_req.addr;
        wr_data_reg <= sel_req.data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wr_en_reg),
    .clr_addr (wr_addr_reg),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .idle     (idle)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of arbitration and busy bits.
module tb_rf_wb_arbiter;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid, iss_en;
  logic            a_ready, b_ready;
  logic [AW-1:0]   a_addr, b_addr, iss_addr, rs1_addr, rs2_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic            rs1_busy, rs2_busy, wr_en, idle;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit              m_busy [NREG];
  bit              m_last_b;
  bit              m_wr_en;
  logic [AW-1:0]   m_wr_addr;
  logic [XLEN-1:0] m_wr_data;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .idle(idle)
  );

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    m_last_b  = 1'b1;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  function automatic bit exp_a_ready();
    return a_valid && (!b_valid || m_last_b);
  endfunction

  function automatic bit exp_b_ready();
    return b_valid && !(a_valid && (!b_valid || m_last_b));
  endfunction

  function automatic bit exp_idle();
    bit any = 1'b0;
    for (int r = 0; r < NREG; r++) any |= m_busy[r];
    return !any && !m_wr_en;
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit fa, fb;
    @(posedge clk);
    fa = exp_a_ready();
    fb = exp_b_ready();
    if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    if (fa) begin
      m_wr_en = (a_addr != 0); m_wr_addr = a_addr; m_wr_data = a_data; m_last_b = 1'b0;
    end else if (fb) begin
      m_wr_en = (b_addr != 0); m_wr_addr = b_addr; m_wr_data = b_data; m_last_b = 1'b1;
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
  endtask

  task automatic set_quiet();
    a_valid = 0; b_valid = 0; iss_en = 0;
    a_addr = '0; b_addr = '0; iss_addr = '0;
    a_data = '0; b_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    set_quiet();
    rst = 1'b1;
    a_valid = 1; a_addr = 5'd2; a_data = 64'h1234;
    model_reset();
    #2;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_checks++; if (wr_addr !== '0 || wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_bus got %0d/%h want 0/0", wr_addr, wr_data); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_a_ready got %b want 1", a_ready); end
    tick();
    a_valid = 0;
    #1;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd2) begin n_fail++; $display("FAIL reset_first_write got en=%b addr=%0d want en=1 addr=2", wr_en, wr_addr); end
    tick();
  endtask

  task automatic test_single_a();
    set_quiet();
    a_valid = 1; a_addr = 5'd5; a_data = 64'hDEAD_BEEF;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL single_latency got wr_en=%b want 0 before edge", wr_en); end
    tick();
    a_valid = 0;
    #1;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_write got en=%b addr=%0d data=%h want 1/5/deadbeef", wr_en, wr_addr, wr_data);
    end
    tick();
    #1;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_hold got en=%b addr=%0d want 0/5", wr_en, wr_addr); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_seq [4];
    exp_seq[0] = 5'd3; exp_seq[1] = 5'd4; exp_seq[2] = 5'd3; exp_seq[3] = 5'd4;
    set_quiet();
    // Prime last grant to B so that A wins the first tie.
    b_valid = 1; b_addr = 5'd4; b_data = 64'h44;
    tick();
    a_valid = 1; a_addr = 5'd3; a_data = 64'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (a_ready && b_ready) begin n_fail++; $display("FAIL b2b_two_readies cycle %0d", i); end
      if (i < 4) begin
        n_checks++;
        if (a_ready !== (exp_seq[i] == 5'd3)) begin
          n_fail++; $display("FAIL b2b_grant cycle %0d got a_ready=%b want %b", i, a_ready, exp_seq[i] == 5'd3);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== exp_seq[i-1]) begin
          n_fail++; $display("FAIL b2b_wr_addr cycle %0d got %0d want %0d", i, wr_addr, exp_seq[i-1]);
        end
      end
      tick();
    end
    set_quiet();
    tick(); tick();
  endtask

  task automatic test_scoreboard();
    set_quiet();
    rs1_addr = 5'd7;
    iss_en = 1; iss_addr = 5'd7;
    tick();
    iss_en = 0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b want 1", rs1_busy); end
    a_valid = 1; a_addr = 5'd7; a_data = 64'h77;
    tick();
    a_valid = 0;
    #1;
    n_checks++; if (wr_en !== 1'b1 || rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_during_write got en=%b busy=%b want 1/1", wr_en, rs1_busy); end
    tick();
    #1;
    n_checks++; if (rs1_busy !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL sb_clear got busy=%b idle=%b want 0/1", rs1_busy, idle); end
    // Reissue while the previous write to r7 retires: set must win.
    iss_en = 1; iss_addr = 5'd7;
    tick();
    iss_en = 0;
    a_valid = 1; a_addr = 5'd7; a_data = 64'h78;
    tick();
    a_valid = 0;
    iss_en = 1; iss_addr = 5'd7;
    #1;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7) begin n_fail++; $display("FAIL sb_retire_setup got en=%b addr=%0d want 1/7", wr_en, wr_addr); end
    tick();
    iss_en = 0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL sb_set_wins got busy=%b idle=%b want 1/0", rs1_busy, idle); end
    a_valid = 1; a_addr = 5'd7; a_data = 64'h79;
    tick();
    a_valid = 0;
    tick();
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear got %b want 0", rs1_busy); end
  endtask

  task automatic test_x0();
    set_quiet();
    b_valid = 1; b_addr = 5'd0; b_data = 64'h1;
    iss_en = 1; iss_addr = 5'd0;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", b_ready); end
    tick();
    set_quiet();
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_dropped got wr_en=%b want 0", wr_en); end
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b/%b want 0/0", rs1_busy, rs2_busy); end
    // x0 write by B still moved the grant, so A wins the next tie.
    a_valid = 1; a_addr = 5'd9; b_valid = 1; b_addr = 5'd10;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL x0_last_gnt got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    tick();
    a_valid = 0;
    tick();
    set_quiet();
    tick(); tick();
  endtask

  task automatic test_async_reset();
    set_quiet();
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    iss_en = 1; iss_addr = 5'd1;
    tick();
    iss_addr = 5'd2;
    a_valid = 1; a_addr = 5'd9; a_data = 64'hABCD;
    tick();
    iss_en = 0; a_valid = 0;
    #1;
    n_checks++;
    if (wr_en !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup got en=%b busy=%b%b want 1/11", wr_en, rs1_busy, rs2_busy);
    end
    rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== '0) begin n_fail++; $display("FAIL arst_wr got en=%b addr=%0d want 0/0", wr_en, wr_addr); end
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b%b want 00", rs1_busy, rs2_busy); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL arst_idle got %b want 1", idle); end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_random();
    bit fa, fb;
    set_quiet();
    for (int c = 0; c < 400; c++) begin
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = AW'($urandom_range(0, 7));
      iss_en   = ($urandom_range(0, 3) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      #1;
      n_checks++;
      if (a_ready !== exp_a_ready() || b_ready !== exp_b_ready()) begin
        n_fail++; $display("FAIL rnd_ready cycle %0d got a=%b b=%b want a=%b b=%b", c, a_ready, b_ready, exp_a_ready(), exp_b_ready());
      end
      n_checks++;
      if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
        n_fail++; $display("FAIL rnd_write cycle %0d got %b/%0d/%h want %b/%0d/%h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      end
      n_checks++;
      if (rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr]) begin
        n_fail++; $display("FAIL rnd_busy cycle %0d r%0d=%b r%0d=%b want %b/%b", c, rs1_addr, rs1_busy, rs2_addr, rs2_busy, m_busy[rs1_addr], m_busy[rs2_addr]);
      end
      n_checks++; if (idle !== exp_idle()) begin n_fail++; $display("FAIL rnd_idle cycle %0d got %b want %b", c, idle, exp_idle()); end
      fa = exp_a_ready();
      fb = exp_b_ready();
      tick();
      // Sources hold their request until accepted.
      if (fa || !a_valid) begin
        a_valid = $urandom_range(0, 1); a_addr = AW'($urandom_range(0, 7));
        a_data = {$urandom, $urandom};
      end
      if (fb || !b_valid) begin
        b_valid = $urandom_range(0, 1); b_addr = AW'($urandom_range(0, 7));
        b_data = {$urandom, $urandom};
      end
    end
    set_quiet();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_back_to_back();
    test_scoreboard();
    test_x0();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
